// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared types and constants for the binary-to-BCD converter
package seven_segment_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } bcd_state_e;

  // Each decimal digit covers at least 3 binary bits (10^k >= 2^(3k)), so
  // ceil(width/3) digits always hold the largest input without losing a carry.
  function automatic int scratch_digits(input int data_width, input int digits);
    int need;
    need = (data_width + 2) / 3;
    return (need > digits) ? need : digits;
  endfunction

endpackage

// File: rtl/binary_to_bcd_if.sv
// rtl/binary_to_bcd_if.sv - request/result bundle between a client and the converter
interface binary_to_bcd_if #(
  parameter int DATA_WIDTH = 14,
  parameter int DIGITS     = 4
);
  import seven_segment_pkg::*;

  logic [DATA_WIDTH-1:0]         data_in;
  logic                          valid_in;
  logic                          ready_out;
  logic [DIGITS*BCD_DIGIT_W-1:0] bcd_out;
  logic                          done;
  logic                          overflow;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  bcd_out,
    input  done,
    input  overflow
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output bcd_out,
    output done,
    output overflow
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble add-3 correction for one BCD nibble
module bcd_digit_adjust
  import seven_segment_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // A digit of 5 or more would exceed 9 after the shift, so pre-bias it by 3.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_DIGIT_W'(5)) begin
      digit_out = digit_in + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/binary_to_bcd.sv
// rtl/binary_to_bcd.sv - sequential double-dabble binary to BCD converter with saturation
module binary_to_bcd
  import seven_segment_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int DIGITS     = 4
) (
  input  logic             clk,
  input  logic             reset,
  binary_to_bcd_if.slave   bus
);

  localparam int SCR_DIGITS = scratch_digits(DATA_WIDTH, DIGITS);
  localparam int SCR_W      = SCR_DIGITS * BCD_DIGIT_W;
  localparam int OUT_W      = DIGITS * BCD_DIGIT_W;
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [OUT_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  bcd_state_e             state;
  bcd_state_e             state_next;
  logic                   ready_c;
  logic                   done_c;

  logic [DATA_WIDTH-1:0]  shift_q;
  logic [SCR_W-1:0]       scratch_q;
  logic [CNT_W-1:0]       count_q;
  logic [OUT_W-1:0]       bcd_q;
  logic                   overflow_q;

  logic [SCR_W-1:0]       adjusted;
  logic [SCR_W-1:0]       step_scratch;
  logic [DATA_WIDTH-1:0]  step_shift;
  logic                   step_overflow;

  // One correction unit per scratch digit, including the guard digits.
  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // One double-dabble step: corrected scratch and binary shift left as one long register.
  always_comb begin
    step_scratch  = {adjusted[SCR_W-2:0], shift_q[DATA_WIDTH-1]};
    step_shift    = shift_q << 1;
    step_overflow = |(step_scratch >> OUT_W);
  end

  // State register; reset wins over any acceptance on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus ready/done, which depend on state alone.
  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.valid_in) begin
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (count_q == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture on acceptance, step while converting, publish on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else if (state == IDLE && bus.valid_in) begin
      shift_q   <= bus.data_in;
      scratch_q <= '0;
      count_q   <= LAST_BIT;
    end else if (state == CONVERT) begin
      shift_q   <= step_shift;
      scratch_q <= step_scratch;
      count_q   <= count_q - 1'b1;
      if (count_q == '0) begin
        bcd_q      <= step_overflow ? ALL_NINES : step_scratch[OUT_W-1:0];
        overflow_q <= step_overflow;
      end
    end
  end

  assign bus.ready_out = ready_c;
  assign bus.done      = done_c;
  assign bus.bcd_out   = bcd_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// tb/tb_binary_to_bcd.sv - directed self-checking bench for binary_to_bcd
module tb_binary_to_bcd;

  localparam int DW = 14;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  binary_to_bcd_if #(.DATA_WIDTH(DW), .DIGITS(ND)) bus ();

  binary_to_bcd #(.DATA_WIDTH(DW), .DIGITS(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic digits_ok(input logic [15:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.ready_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " ready"}, 32'(bus.ready_out), 32'd1);
  endtask

  task automatic count_done(input int ncyc, output int k);
    k = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (bus.done === 1'b1) k++;
    end
  endtask

  task automatic run_conv(input int v, input string tag, output int done_cyc);
    int n;
    wait_ready(tag);
    bus.data_in  = DW'(v);
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    n = 1;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    done_cyc = cyc;
    check({tag, " latency"}, 32'(n), 32'd15);
    check({tag, " bcd"}, 32'(bus.bcd_out), 32'(ref_bcd(v)));
    check({tag, " ovf"}, 32'(bus.overflow), 32'(v > 9999));
    check({tag, " digits"}, 32'(digits_ok(bus.bcd_out)), 32'd1);
  endtask

  initial begin
    int t0;
    int t1;
    int k;
    int n;
    int boundary [6] = '{9998, 9999, 10000, 10001, 16382, 16383};

    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    tick();
    tick();
    check("reset ready", 32'(bus.ready_out), 32'd1);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset bcd", 32'(bus.bcd_out), 32'h0);
    check("reset ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    tick();

    // basic conversion, then result holds and done is a single pulse
    run_conv(1234, "c1234", t0);
    check("c1234 bcd literal", 32'(bus.bcd_out), 32'h1234);
    tick();
    check("c1234 done one cycle", 32'(bus.done), 32'd0);
    check("c1234 hold bcd", 32'(bus.bcd_out), 32'h1234);
    check("c1234 ready after", 32'(bus.ready_out), 32'd1);

    // back-to-back 0 then 9999
    run_conv(0, "c0", t0);
    run_conv(9999, "c9999", t1);
    check("b2b done spacing", 32'(t1 - t0), 32'd16);
    check("c9999 bcd literal", 32'(bus.bcd_out), 32'h9999);

    // saturation then recovery
    run_conv(16383, "c16383", t0);
    check("c16383 ovf literal", 32'(bus.overflow), 32'd1);
    run_conv(42, "c42", t0);
    check("c42 bcd literal", 32'(bus.bcd_out), 32'h0042);

    // valid held high with changing data while converting
    wait_ready("hold");
    bus.data_in  = DW'(3141);
    bus.valid_in = 1'b1;
    tick();
    n = 1;
    while (bus.done !== 1'b1 && n < 40) begin
      bus.data_in = DW'($urandom_range(0, 16383));
      tick();
      n++;
    end
    bus.valid_in = 1'b0;
    check("hold latency", 32'(n), 32'd15);
    check("hold bcd", 32'(bus.bcd_out), 32'h3141);
    count_done(20, k);
    check("hold extra done", 32'(k), 32'd0);

    // reset during the 7th convert cycle
    wait_ready("abort");
    bus.data_in  = DW'(5678);
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort done", 32'(bus.done), 32'd0);
    check("abort bcd", 32'(bus.bcd_out), 32'h0);
    check("abort ovf", 32'(bus.overflow), 32'd0);
    check("abort ready", 32'(bus.ready_out), 32'd1);
    count_done(20, k);
    check("abort no done", 32'(k), 32'd0);
    run_conv(5678, "c5678", t0);
    check("c5678 bcd literal", 32'(bus.bcd_out), 32'h5678);

    // reset beats acceptance on the same edge
    wait_ready("prio");
    bus.data_in  = DW'(777);
    bus.valid_in = 1'b1;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    check("prio ready", 32'(bus.ready_out), 32'd1);
    check("prio bcd", 32'(bus.bcd_out), 32'h0);
    count_done(20, k);
    check("prio no done", 32'(k), 32'd0);

    // boundary values and a strided sweep of the input range
    foreach (boundary[i]) run_conv(boundary[i], $sformatf("bnd%0d", boundary[i]), t0);
    for (int v = 0; v <= 16383; v += 7) begin
      run_conv(v, $sformatf("sw%0d", v), t0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
